// File: rtl/axim_read_checker.sv
// -----------------------------------------------------------------------------
// axim_read_checker
//
// Passive checker for the AXI read path between the read master and the SDRAM
// subsystem. It snoops AR and R handshakes, queues outstanding bursts and
// checks every returned beat against the incrementing-address pattern written
// by the write master (data = word address[15:0] ^ PATTERN_XOR). Results drive
// the board-level pass/fail indication. No AXI signal is ever driven.
//
// Ports:
//   clk, reset_n            clock; asynchronous active-low reset
//   clear_in                synchronous clear of FIFO, counters and flags
//   axi_ar*_in              snooped AR channel (valid, ready, addr, len)
//   axi_r*_in               snooped R channel (valid, ready, data, resp, last)
//   burst_done_out          one-cycle pulse per closed burst
//   burst_count_out         closed bursts, saturating
//   error_count_out         erroneous beats, saturating
//   first_err_*_out         sticky capture of the first erroneous beat
//   protocol_err_out        sticky protocol violation
//   pass_out                no errors, no violation, at least one burst
// -----------------------------------------------------------------------------
module axim_read_checker #(
  parameter int          ADDR_W      = 25,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] PATTERN_XOR = 16'h0000,
  parameter int          ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_in,
  input  logic                 axi_arvalid_in,
  input  logic                 axi_arready_in,
  input  logic [ADDR_W-1:0]    axi_araddr_in,
  input  logic [7:0]           axi_arlen_in,
  input  logic                 axi_rvalid_in,
  input  logic                 axi_rready_in,
  input  logic [15:0]          axi_rdata_in,
  input  logic [1:0]           axi_rresp_in,
  input  logic                 axi_rlast_in,
  output logic                 burst_done_out,
  output logic [15:0]          burst_count_out,
  output logic [ERR_CNT_W-1:0] error_count_out,
  output logic                 first_err_valid_out,
  output logic [ADDR_W-1:0]    first_err_addr_out,
  output logic [15:0]          first_err_data_out,
  output logic                 protocol_err_out,
  output logic                 pass_out
);

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } ar_entry_t;

  // NOTE: the burst FIFO storage has no reset; the pointers and count define
  // which entries are valid, so resetting the array would only add reset fanout.
  ar_entry_t fifo_mem [FIFO_DEPTH];

  state_e                state_q, state_d;
  logic                  run_q, run_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [7:0]            beat_q, beat_d;
  logic                  burst_done_q, burst_done_d;
  logic [15:0]           burst_count_q, burst_count_d;
  logic [ERR_CNT_W-1:0]  error_count_q, error_count_d;
  logic                  first_err_valid_q, first_err_valid_d;
  logic [ADDR_W-1:0]     first_err_addr_q, first_err_addr_d;
  logic [15:0]           first_err_data_q, first_err_data_d;
  logic                  protocol_err_q, protocol_err_d;
  logic                  pass_q, pass_d;

  ar_entry_t         head;
  logic [ADDR_W-1:0] exp_addr;
  logic [15:0]       exp_data;
  logic              ar_beat, r_beat, chk, stray, is_last, len_err, beat_err;
  logic              close, push, pop, full, drop;

  // NOTE: every combinational output gets a default at the top of the block so
  // no path through the if/case structure can leave it unassigned (no latches);
  // blocking '=' is used here, non-blocking '<=' only in clocked blocks.
  always_comb begin
    run_d    = 1'b1;
    head     = fifo_mem[rd_ptr_q];
    exp_addr = head.addr + ADDR_W'(beat_q);
    exp_data = exp_addr[15:0] ^ PATTERN_XOR;

    // Nothing is accepted until the cycle after reset release has been seen.
    ar_beat = run_q && axi_arvalid_in && axi_arready_in;
    r_beat  = run_q && axi_rvalid_in && axi_rready_in;

    // The head is read straight from storage, so an AR landing in the same
    // cycle as an R beat on an empty FIFO is not yet visible: the R is stray.
    stray    = r_beat && (state_q == IDLE);
    chk      = r_beat && (state_q == ACTIVE);
    is_last  = (beat_q == head.len);
    len_err  = (axi_rlast_in != is_last);
    beat_err = chk && ((axi_rdata_in != exp_data) || (axi_rresp_in != 2'b00) || len_err);
    close    = chk && (axi_rlast_in || is_last);

    pop  = close;
    full = (count_q == DEPTH_C);
    push = ar_beat && (!full || pop);
    drop = ar_beat && full && !pop;

    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    beat_d            = beat_q;
    state_d           = state_q;
    burst_done_d      = 1'b0;
    burst_count_d     = burst_count_q;
    error_count_d     = error_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_addr_d  = first_err_addr_q;
    first_err_data_d  = first_err_data_q;
    protocol_err_d    = protocol_err_q;
    pass_d            = (error_count_q == '0) && !protocol_err_q && (burst_count_q != '0);

    if (clear_in) begin
      wr_ptr_d          = '0;
      rd_ptr_d          = '0;
      count_d           = '0;
      beat_d            = '0;
      state_d           = IDLE;
      burst_count_d     = '0;
      error_count_d     = '0;
      first_err_valid_d = 1'b0;
      first_err_addr_d  = '0;
      first_err_data_d  = '0;
      protocol_err_d    = 1'b0;
      pass_d            = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      state_d = (count_d != '0) ? ACTIVE : IDLE;

      if (close)    beat_d = '0;
      else if (chk) beat_d = beat_q + 8'd1;

      burst_done_d = close;
      if (close && (burst_count_q != '1)) burst_count_d = burst_count_q + 16'd1;
      if (beat_err && (error_count_q != '1)) error_count_d = error_count_q + ERR_CNT_W'(1);

      if (beat_err && !first_err_valid_q) begin
        first_err_valid_d = 1'b1;
        first_err_addr_d  = exp_addr;
        first_err_data_d  = axi_rdata_in;
      end

      if (stray || drop || (chk && len_err)) protocol_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear_in) fifo_mem[wr_ptr_q] <= '{addr: axi_araddr_in, len: axi_arlen_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q             <= 1'b0;
      state_q           <= IDLE;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      beat_q            <= '0;
      burst_done_q      <= 1'b0;
      burst_count_q     <= '0;
      error_count_q     <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      first_err_data_q  <= '0;
      protocol_err_q    <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      run_q             <= run_d;
      state_q           <= state_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      beat_q            <= beat_d;
      burst_done_q      <= burst_done_d;
      burst_count_q     <= burst_count_d;
      error_count_q     <= error_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_addr_q  <= first_err_addr_d;
      first_err_data_q  <= first_err_data_d;
      protocol_err_q    <= protocol_err_d;
      pass_q            <= pass_d;
    end
  end

  assign burst_done_out      = burst_done_q;
  assign burst_count_out     = burst_count_q;
  assign error_count_out     = error_count_q;
  assign first_err_valid_out = first_err_valid_q;
  assign first_err_addr_out  = first_err_addr_q;
  assign first_err_data_out  = first_err_data_q;
  assign protocol_err_out    = protocol_err_q;
  assign pass_out            = pass_q;

endmodule
